// File: rtl/ups_drp_adc_if.sv
// DRP register bus between a host (master) and the ups_drp_adc block (slave).
//   den    request strobe, one cycle per transaction
//   daddr  7-bit register address
//   di     16-bit write data
//   dwe    write enable, qualifies den
//   drdy   one-cycle response strobe
//   dout   16-bit read data, zero outside drdy (the DRP name "do" is a reserved word)
interface ups_drp_adc_if;
  logic        den;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic        dwe;
  logic        drdy;
  logic [15:0] dout;

  modport master (
    output den,
    output daddr,
    output di,
    output dwe,
    input  drdy,
    input  dout
  );

  modport slave (
    input  den,
    input  daddr,
    input  di,
    input  dwe,
    output drdy,
    output dout
  );
endinterface

// File: rtl/ups_drp_adc.sv
// Periodic SPI ADC sampler with a DRP status/config register port.
//
// A free-running timer requests a 16-bit SPI mode-0 frame every CONV_PERIOD clocks. The low
// 12 bits of each frame are stored, left-justified, in the status register at address CHANNEL.
// Config registers 0-2 live at 7'h40-7'h42; bit 15 of config 0 inhibits new conversions.
//
// Ports:
//   clk, rst_n        clock (rising edge) and synchronous active-low reset
//   drp               DRP slave (den/daddr/di/dwe in, drdy/dout out)
//   busy              high from chip-select setup through the DONE cycle
//   channel           channel of the last completed conversion
//   eoc, eos          one-cycle end-of-conversion / end-of-sequence pulses
//   spi_cs_n, spi_sclk, spi_miso   external ADC SPI link
//
// Build option: define UPS_DRP_ADC_AVG_EN to store a running average of the last four raw
// results instead of each raw result.
module ups_drp_adc #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned CONV_PERIOD = 1000,
  parameter logic [4:0]  CHANNEL     = 5'h11,
  parameter int unsigned DRP_LAT     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  ups_drp_adc_if.slave drp,
  output logic         busy,
  output logic [4:0]   channel,
  output logic         eoc,
  output logic         eos,
  output logic         spi_cs_n,
  output logic         spi_sclk,
  input  logic         spi_miso
);

  localparam int unsigned       TimerW     = (CONV_PERIOD > 1) ? $clog2(CONV_PERIOD) : 1;
  localparam logic [TimerW-1:0] TimerLast  = TimerW'(CONV_PERIOD - 1);
  localparam logic [7:0]        DivLast    = 8'(CLK_DIV - 1);
  localparam logic [3:0]        LatLast    = 4'(DRP_LAT - 1);
  localparam logic [6:0]        AddrResult = {2'b00, CHANNEL};

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StShift,
    StCsHold,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        div_q, div_d;
  logic [3:0]        bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic [11:0]       shift_q, shift_d;
  logic [TimerW-1:0] timer_q;
  logic              timer_wrap;
  logic              hold;
  logic              conv_start;

  logic [15:0]       stat_q;
  logic [4:0]        chan_q;
  logic              eoc_q;
  logic [15:0]       cfg_q [3];

  logic              pend_q;
  logic [3:0]        lat_q;
  logic [15:0]       resp_q;
  logic              accept;
  logic              drdy;
  logic [15:0]       rd_data;

  logic [11:0]       raw;
  logic [11:0]       res;

  // ---------------------------------------------------------------------------------------------
  // Conversion timer: wraps every CONV_PERIOD cycles regardless of whether the wrap is used.
  // ---------------------------------------------------------------------------------------------
  assign timer_wrap = (timer_q == TimerLast);
  assign hold       = cfg_q[0][15];
  assign conv_start = timer_wrap && !busy && !hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (timer_wrap) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TimerW'(1);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // SPI frame FSM
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        if (conv_start) begin
          state_d = StCsSetup;
          div_d   = '0;
        end
      end
      StCsSetup: begin
        if (div_q == DivLast) begin
          state_d = StShift;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (!sclk_q) begin
            // Rising SCLK edge: sample MISO. Only the last 12 bits survive the shift, which
            // drops frame bits [15:12] without extra logic.
            sclk_d  = 1'b1;
            shift_d = {shift_q[10:0], spi_miso};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 4'd15) begin
              state_d = StCsHold;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StCsHold: begin
        if (div_q == DivLast) begin
          state_d = StDone;
          div_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Chip select is registered from the next state so the pin never glitches on decode.
  assign cs_n_d = !(state_d inside {StCsSetup, StShift, StCsHold});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      shift_q <= shift_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Result path
  // ---------------------------------------------------------------------------------------------
  assign raw = shift_q;

`ifdef UPS_DRP_ADC_AVG_EN
  logic [11:0] hist_q [3];
  logic [13:0] sum;

  assign sum = 14'(raw) + 14'(hist_q[0]) + 14'(hist_q[1]) + 14'(hist_q[2]);
  assign res = 12'(sum >> 2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        hist_q[i] <= '0;
      end
    end else if (state_q == StDone) begin
      hist_q[0] <= raw;
      hist_q[1] <= hist_q[0];
      hist_q[2] <= hist_q[1];
    end
  end
`else
  assign res = raw;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_q <= '0;
      chan_q <= '0;
      eoc_q  <= 1'b0;
    end else begin
      eoc_q <= (state_q == StDone);
      if (state_q == StDone) begin
        stat_q <= {res, 4'b0000};
        chan_q <= CHANNEL;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // DRP port. Read data is captured from the pre-edge register values, so a result stored on
  // the same edge is not seen by that read. The response counts as pending up to and
  // including its drdy cycle.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    if (drp.daddr == AddrResult) begin
      rd_data = stat_q;
    end else if (drp.daddr == 7'h40) begin
      rd_data = cfg_q[0];
    end else if (drp.daddr == 7'h41) begin
      rd_data = cfg_q[1];
    end else if (drp.daddr == 7'h42) begin
      rd_data = cfg_q[2];
    end
  end

  assign accept = drp.den && !pend_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      lat_q  <= '0;
      resp_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cfg_q[i] <= '0;
      end
    end else if (accept) begin
      pend_q <= 1'b1;
      lat_q  <= LatLast;
      resp_q <= drp.dwe ? 16'h0000 : rd_data;
      if (drp.dwe) begin
        if (drp.daddr == 7'h40) begin
          cfg_q[0] <= drp.di;
        end else if (drp.daddr == 7'h41) begin
          cfg_q[1] <= drp.di;
        end else if (drp.daddr == 7'h42) begin
          cfg_q[2] <= drp.di;
        end
      end
    end else if (pend_q) begin
      if (lat_q == 4'd0) begin
        pend_q <= 1'b0;
      end else begin
        lat_q <= lat_q - 4'd1;
      end
    end
  end

  assign drdy     = pend_q && (lat_q == 4'd0);
  assign drp.drdy = drdy;
  assign drp.dout = drdy ? resp_q : 16'h0000;

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  assign busy     = (state_q != StIdle);
  assign channel  = chan_q;
  assign eoc      = eoc_q;
  assign eos      = eoc_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;

endmodule

// File: doc/ups_drp_adc.md
UPS_DRP_ADC -- requirements
Module: ups_drp_adc

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SPI SCLK half-period in clk cycles; legal range 2-255.
REQ-002 SHALL have parameter CONV_PERIOD, default 1000: clk cycles between conversion starts; legal minimum 34*CLK_DIV+4.
REQ-003 SHALL have parameter CHANNEL, default 5'h11: channel number reported, and DRP status address of the result.
REQ-004 SHALL have parameter DRP_LAT, default 2: den-to-drdy latency in clk cycles; legal range 1-15.
REQ-005 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have DRP request ports: den in 1 (read/write strobe); daddr in 7 (register address); di in 16 (write data); dwe in 1 (write enable).
REQ-008 SHALL have DRP response ports: drdy out 1 (response strobe); do out 16 (read data).
REQ-009 SHALL have conversion status ports: busy out 1 (conversion in progress); channel out 5 (last converted channel); eoc out 1 (end-of-conversion pulse); eos out 1 (end-of-sequence pulse).
REQ-010 SHALL have external ADC SPI ports: spi_cs_n out 1; spi_sclk out 1; spi_miso in 1.

Function
REQ-011 SHALL run a free timer 0..CONV_PERIOD-1 and request a conversion on wrap; a wrap while busy=1 SHALL be dropped and the timer restarted.
REQ-012 SHALL use FSM IDLE -> CS_SETUP (CLK_DIV cycles, cs_n=0, sclk=0) -> SHIFT (16 SCLK periods) -> CS_HOLD (CLK_DIV cycles, sclk=0) -> DONE (1 cycle) -> IDLE.
REQ-013 SHALL use SPI mode 0 in SHIFT: sclk low CLK_DIV cycles, high CLK_DIV cycles; spi_miso sampled on the clk edge that drives sclk high; MSB first.
REQ-014 SHALL drive busy=1 from CS_SETUP entry through DONE, for exactly 34*CLK_DIV+1 cycles.
REQ-015 SHALL take the 12-bit result from frame bits [11:0] and discard bits [15:12].
REQ-016 SHALL, in DONE, store {result,4'b0000} into the status register at address CHANNEL, set channel=CHANNEL, and pulse eoc and eos high for exactly one cycle.
REQ-017 SHALL accept den only when no response is pending; a den arriving while pending SHALL be ignored and produce no drdy.
REQ-018 SHALL assert drdy for one cycle exactly DRP_LAT cycles after the accepted den cycle.
REQ-019 SHALL drive do with read data only while drdy=1; do SHALL be 16'h0000 otherwise.
REQ-020 SHALL capture read data in the den cycle; a DONE store in the same cycle SHALL NOT be visible to that read.
REQ-021 SHALL return the following on reads: address CHANNEL gives the result register; 7'h40-7'h42 give config registers 0-2; all other addresses give 16'h0000.
REQ-022 SHALL, for den with dwe=1 at 7'h40-7'h42, write di into the config register; writes to other addresses SHALL be ignored. Every write SHALL still produce drdy per REQ-018, with do=0.
REQ-023 SHALL treat config register 0 bit 15 (HOLD) as a conversion inhibit: while HOLD=1, timer wraps SHALL be dropped, and a conversion already in progress SHALL complete.

Reset
REQ-024 SHALL, on rst_n=0, set spi_cs_n=1, spi_sclk=0, busy=0, eoc=0, eos=0, drdy=0, do=0, channel=0, result=0, config regs=0, timer=0, FSM=IDLE, with no response pending.
REQ-025 SHALL, on reset mid-frame, raise cs_n at the next edge and discard the partial frame.
REQ-026 SHALL start the first conversion CONV_PERIOD cycles after rst_n rises.

Configuration
REQ-027 SHALL, with macro UPS_DRP_ADC_AVG_EN defined, store (sum of the 4 most recent raw results)>>2 using a 14-bit sum; history SHALL reset to 0, so the first three outputs average in zeros.
REQ-028 SHALL, with UPS_DRP_ADC_AVG_EN undefined, store each raw result directly and contain no averaging logic.

Verification
REQ-029 Reset release, CLK_DIV=4, CONV_PERIOD=1000, MISO frame 16'hFABC -> cs_n falls at cycle 1000; eoc/eos pulse at cycle 1137; DRP read of 7'h11 gives do=16'hABC0.
REQ-030 den at 7'h11 with DRP_LAT=2 -> drdy exactly 2 cycles later for 1 cycle; a second den 1 cycle after the first is ignored, giving one drdy only.
REQ-031 Write 7'h40=16'h8000, then run for 3000 cycles -> no cs_n activity; write 16'h0000 -> conversions resume on the next timer wrap.
REQ-032 Write 7'h05=16'h1234 then read 7'h05 -> drdy on both, read do=16'h0000; read 7'h41 after writing 16'h00A5 -> 16'h00A5.
REQ-033 rst_n=0 at SCLK period 8 of a frame -> cs_n=1 and busy=0 next cycle; no eoc; result remains 0.
REQ-034 AVG_EN, raw results 0x100, 0x200, 0x300, 0x400 -> stored values 0x040, 0x0C0, 0x180, 0x280, each <<4.
